// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings and request record for the data-memory responder.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    // One accepted request; read+write together collapses to a store.
    typedef struct packed {
        logic [29:0] addr;
        logic [1:0]  offset;
        logic        is_store;
        logic [3:0]  byte_enable;
        logic [31:0] wdata;
        logic [2:0]  funct3;
    } dmem_req_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_unit.sv
// Load extraction: picks the byte/halfword named by offset and extends it per funct3.
module load_unit
    import riscv_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // Halfwords ignore offset[0]; misalignment is silently rounded down.
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = sext8(byte_sel);
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LH:   data = sext16(half_sel);
            F3_LHU:  data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array behind a fixed-wait-state request/response handshake,
// busy doubles as the memory-stage stall.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] req_addr,
    input  logic [1:0]  req_offset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [3:0]  req_byte_enable,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        busy,
    output logic        resp_valid,
    output logic        resp_is_load,
    output logic [31:0] resp_rdata
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    dmem_state_t state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept;
    logic        fire;

    dmem_req_t   live_req, held_req, op;
    logic [IDX_W-1:0] op_idx;
    logic        unused_addr_hi;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;

    logic        rsp_is_load;
    logic [2:0]  rsp_funct3;
    logic [1:0]  rsp_offset;
    logic [31:0] ld_data;

    always_comb begin
        live_req             = '0;
        live_req.addr        = req_addr;
        live_req.offset      = req_offset;
        live_req.is_store    = req_write;
        live_req.byte_enable = req_byte_enable;
        live_req.wdata       = req_wdata;
        live_req.funct3      = req_funct3;
    end

    always_ff @(posedge clk) begin
        if (accept)
            held_req <= live_req;
    end

    // With no wait states the array is serviced on the accept edge itself.
    assign op             = (WAIT_STATES == 0) ? live_req : held_req;
    assign op_idx         = op.addr[IDX_W-1:0];
    assign unused_addr_hi = ^op.addr[29:IDX_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fire       = 1'b0;
        busy       = (state == WAIT);
        accept     = (req_read | req_write) & ~busy;
        case (state)
            IDLE, RESP: begin
                state_next = IDLE;
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                        fire       = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    fire       = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Single-port array: one access per fire; reset gates it so an aborted store is lost.
    always_ff @(posedge clk) begin
        if (rst && fire) begin
            if (op.is_store) begin
                for (int i = 0; i < WORD_BYTES; i++)
                    if (op.byte_enable[i])
                        mem[op_idx][8*i +: 8] <= op.wdata[8*i +: 8];
            end else begin
                rd_word <= mem[op_idx];
            end
        end
    end

    // Response-side copies so a back-to-back accept cannot disturb the held response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_is_load <= 1'b0;
            rsp_funct3  <= F3_LW;
            rsp_offset  <= 2'd0;
        end else if (fire) begin
            rsp_is_load <= ~op.is_store;
            rsp_funct3  <= op.funct3;
            rsp_offset  <= op.offset;
        end
    end

    load_unit u_load (
        .word   (rd_word),
        .funct3 (rsp_funct3),
        .offset (rsp_offset),
        .data   (ld_data)
    );

    assign resp_valid   = (state == RESP);
    assign resp_is_load = rsp_is_load;
    assign resp_rdata   = rsp_is_load ? ld_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) against a word-array model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    typedef struct {
        bit          ld;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_q = 1'b0;
    logic [29:0] i_addr [2];
    logic [1:0]  i_off  [2];
    logic [1:0]  i_rd, i_wr;
    logic [3:0]  i_be   [2];
    logic [31:0] i_wd   [2];
    logic [2:0]  i_f3   [2];
    logic [1:0]  busy, rv, rl;
    logic [31:0] rdat   [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int busy1_seen = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] mdl [2][DEPTH];
    logic [31:0] last_rd [2];
    logic        last_ld [2];

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut0 (
        .clk(clk), .rst(rst), .req_addr(i_addr[0]), .req_offset(i_off[0]),
        .req_read(i_rd[0]), .req_write(i_wr[0]), .req_byte_enable(i_be[0]),
        .req_wdata(i_wd[0]), .req_funct3(i_f3[0]), .busy(busy[0]),
        .resp_valid(rv[0]), .resp_is_load(rl[0]), .resp_rdata(rdat[0]));

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst(rst), .req_addr(i_addr[1]), .req_offset(i_off[1]),
        .req_read(i_rd[1]), .req_write(i_wr[1]), .req_byte_enable(i_be[1]),
        .req_wdata(i_wd[1]), .req_funct3(i_f3[1]), .busy(busy[1]),
        .resp_valid(rv[1]), .resp_is_load(rl[1]), .resp_rdata(rdat[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Loads described as shift-and-mask of the stored word.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic issue(input int u, input bit rd, input bit wr, input logic [29:0] a,
                         input logic [1:0] off, input logic [3:0] be, input logic [31:0] wd,
                         input logic [2:0] f3, input bit track = 1'b1);
        exp_t e;
        int n = 0;
        int idx;
        i_rd[u] = rd; i_wr[u] = wr; i_addr[u] = a; i_off[u] = off;
        i_be[u] = be; i_wd[u] = wd; i_f3[u] = f3;
        while (busy[u] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (busy[u]) chk("accept_timeout", 32'd1, 32'd0);
        else if (track) begin
            idx   = int'(a % DEPTH);
            e.cyc = cyc + 1 + ((u == 0) ? 2 : 0);
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mdl[u][idx][8*i +: 8] = wd[8*i +: 8];
                e.ld   = 1'b0;
                e.data = 32'd0;
            end else begin
                e.ld   = 1'b1;
                e.data = ref_load(mdl[u][idx], f3, off);
            end
            if (u == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int u, input int n);
        i_rd[u] = 1'b0;
        i_wr[u] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic rand_req(input int u);
        int k;
        k = $urandom_range(0, 3);
        issue(u, k != 1, (k == 1) || (k == 2),
              30'(($urandom_range(0, 7) * DEPTH) + $urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
              3'($urandom_range(0, 7)));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy[1]) busy1_seen++;
        for (int u = 0; u < 2; u++) begin
            if (!rst_q) begin
                last_rd[u] = 32'd0;
                last_ld[u] = 1'b0;
            end
            if (rv[u]) begin
                if ((u == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    chk("resp_is_load", 32'(rl[u]), 32'(e.ld));
                    chk("resp_rdata", rdat[u], e.data);
                    chk("resp_latency_cycle", cyc, e.cyc);
                end
                last_rd[u] = rdat[u];
                last_ld[u] = rl[u];
            end else begin
                chk("hold_rdata", rdat[u], last_rd[u]);
                chk("hold_is_load", 32'(rl[u]), 32'(last_ld[u]));
            end
        end
    end

    initial begin
        i_rd = '0;
        i_wr = '0;
        for (int u = 0; u < 2; u++) begin
            i_addr[u] = '0; i_off[u] = '0; i_be[u] = '0; i_wd[u] = '0; i_f3[u] = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", 32'(busy[u]), 32'd0);
            chk("rst_resp_valid", 32'(rv[u]), 32'd0);
            chk("rst_is_load", 32'(rl[u]), 32'd0);
            chk("rst_rdata", rdat[u], 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        for (int u = 0; u < 2; u++) begin
            for (int w = 0; w < 16; w++) issue(u, 1'b0, 1'b1, 30'(w), 2'd0, 4'hF, $urandom, 3'b010);
            idle(u, 4);
        end

        // Store then LW with the wait-state timing observed directly.
        issue(0, 1'b0, 1'b1, 30'd5, 2'd0, 4'hF, 32'hDEADBEEF, 3'b010);
        i_wr[0] = 1'b0;
        chk("t1_busy_wait1", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("t1_busy_wait2", 32'(busy[0]), 32'd1);
        @(negedge clk);
        chk("t1_busy_resp", 32'(busy[0]), 32'd0);
        chk("t1_ack_valid", 32'(rv[0]), 32'd1);
        issue(0, 1'b1, 1'b0, 30'd5, 2'd0, 4'h0, 32'd0, 3'b010);
        idle(0, 4);

        // Byte-lane merge and extraction at offset 2.
        issue(0, 1'b0, 1'b1, 30'd7, 2'd0, 4'hF, 32'h11223344, 3'b010);
        issue(0, 1'b0, 1'b1, 30'd7, 2'd0, 4'b0100, 32'h00AA0000, 3'b010);
        issue(0, 1'b1, 1'b0, 30'd7, 2'd2, 4'h0, 32'd0, 3'b000);
        issue(0, 1'b1, 1'b0, 30'd7, 2'd2, 4'h0, 32'd0, 3'b100);
        issue(0, 1'b1, 1'b0, 30'd7, 2'd2, 4'h0, 32'd0, 3'b001);
        issue(0, 1'b1, 1'b0, 30'd7, 2'd2, 4'h0, 32'd0, 3'b101);
        issue(0, 1'b1, 1'b0, 30'd7, 2'd0, 4'h0, 32'd0, 3'b010);

        // Sign handling, including a misaligned halfword.
        issue(0, 1'b0, 1'b1, 30'd9, 2'd0, 4'hF, 32'h8000FF80, 3'b010);
        issue(0, 1'b1, 1'b0, 30'd9, 2'd0, 4'h0, 32'd0, 3'b000);
        issue(0, 1'b1, 1'b0, 30'd9, 2'd2, 4'h0, 32'd0, 3'b101);
        issue(0, 1'b1, 1'b0, 30'd9, 2'd3, 4'h0, 32'd0, 3'b001);

        // Read+write together, address aliasing, empty byte enable.
        issue(0, 1'b1, 1'b1, 30'd11, 2'd0, 4'hF, 32'hCAFEF00D, 3'b010);
        issue(0, 1'b1, 1'b0, 30'd11, 2'd0, 4'h0, 32'd0, 3'b010);
        issue(0, 1'b0, 1'b1, 30'(DEPTH + 1), 2'd0, 4'hF, 32'h13579BDF, 3'b010);
        issue(0, 1'b1, 1'b0, 30'd1, 2'd0, 4'h0, 32'd0, 3'b010);
        issue(0, 1'b0, 1'b1, 30'd2, 2'd0, 4'h0, 32'hFFFFFFFF, 3'b010);
        issue(0, 1'b1, 1'b0, 30'd2, 2'd0, 4'h0, 32'd0, 3'b010);
        idle(0, 4);

        // Reset while the store waits: it must vanish without a response.
        issue(0, 1'b0, 1'b1, 30'd3, 2'd0, 4'hF, 32'h5A5A5A5A, 3'b010, 1'b0);
        i_wr[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("t5_busy_after_rst", 32'(busy[0]), 32'd0);
        chk("t5_no_resp", 32'(rv[0]), 32'd0);
        idle(0, 5);
        issue(0, 1'b1, 1'b0, 30'd3, 2'd0, 4'h0, 32'd0, 3'b010);
        idle(0, 4);

        for (int n = 0; n < 300; n++) begin
            rand_req(0);
            if ($urandom_range(0, 3) == 0) idle(0, $urandom_range(0, 3));
        end
        idle(0, 8);

        // Zero wait states: requests held every cycle.
        issue(1, 1'b0, 1'b1, 30'd4, 2'd0, 4'hF, 32'hA5C3E1F0, 3'b010);
        issue(1, 1'b1, 1'b0, 30'd4, 2'd0, 4'h0, 32'd0, 3'b010);
        issue(1, 1'b0, 1'b1, 30'd4, 2'd0, 4'b0011, 32'h00001234, 3'b010);
        issue(1, 1'b1, 1'b0, 30'd4, 2'd0, 4'h0, 32'd0, 3'b001);
        for (int n = 0; n < 300; n++) rand_req(1);
        idle(1, 8);

        chk("ws0_busy_cycles", 32'(busy1_seen), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
